// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - control word width and the bit position of every control field
//   - NOP control word (all-zero), PC select and forwarding select codes
//   - FSM state type
//   - dst_hit(): does a stage writer collide with the ID-stage sources
// Optional feature macro used by the importing files: HAZARD_FORWARDING_EN
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int CW_W  = 15;
    localparam int REG_W = 5;

    // {RegDst,RegWrite,MemtoReg,Jump,JmpandLink,MemRead,MemWrite,
    //  BrEq,BrNe,ALUSrc,Issigned,ALUop[3:0]}
    localparam int CW_REGDST    = 14;
    localparam int CW_REGWRITE  = 13;
    localparam int CW_MEMTOREG  = 12;
    localparam int CW_JUMP      = 11;
    localparam int CW_JAL       = 10;
    localparam int CW_MEMREAD   = 9;
    localparam int CW_MEMWRITE  = 8;
    localparam int CW_BREQ      = 7;
    localparam int CW_BRNE      = 6;
    localparam int CW_ALUSRC    = 5;
    localparam int CW_ISSIGNED  = 4;
    localparam int CW_ALUOP_MSB = 3;
    localparam int CW_ALUOP_LSB = 0;

    localparam logic [CW_W-1:0] CTRL_NOP = '0;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // A writer hits when it writes a non-zero register that the ID
    // instruction reads ($0 never creates a dependence).
    function automatic logic dst_hit(
        input logic             reg_write,
        input logic [REG_W-1:0] dst,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             uses_rt
    );
        return reg_write && (dst != '0) &&
               ((dst == rs) || (uses_rt && (dst == rt)));
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational hazard classification for the instruction in ID.
// Ports:
//   ex_reg_write, ex_mem_read, ex_dst  in   EX-stage writer info
//   mem_reg_write, mem_dst             in   MEM-stage writer info
//   id_rs, id_rt, id_uses_rt           in   ID-stage sources
//   stall_req                          out  ID instruction must be held
//   stall_len                          out  total stall cycles (0..2)
// Macro HAZARD_FORWARDING_EN: with forwarding only load-use stalls.
// -----------------------------------------------------------------------------
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] mem_dst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             stall_req,
    output logic [1:0]       stall_len
);

    logic ex_hit;
    logic mem_hit;
    logic load_use;

    always_comb begin
        ex_hit   = dst_hit(ex_reg_write, ex_dst, id_rs, id_rt, id_uses_rt);
        mem_hit  = dst_hit(mem_reg_write, mem_dst, id_rs, id_rt, id_uses_rt);
        load_use = ex_hit & ex_mem_read;

`ifdef HAZARD_FORWARDING_EN
        // ALU results are forwarded; only a load still in EX is too late.
        stall_len = load_use ? 2'd1 : 2'd0;
`else
        if (load_use)
            stall_len = 2'd1;
        else if (ex_hit)
            stall_len = 2'd2;
        else if (mem_hit)
            stall_len = 2'd1;
        else
            stall_len = 2'd0;
`endif

        stall_req = (stall_len != 2'd0);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Carries the decoded control word and destination register through
// ID/EX, EX/MEM and MEM/WB, detects load-use/RAW hazards, resolves branches
// in EX and redirects jumps from ID. Bubbles are all-zero control words.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   id_ctrl, id_rs, id_rt      ID instruction control word and sources
//   id_uses_rt, id_dst         ID reads rt / destination register
//   ex_alu_zero                ALU zero flag of the EX instruction
//   pc_write, ifid_write       PC and IF/ID enables (low while stalled)
//   ifid_flush                 clear IF/ID (taken branch or jump)
//   pc_sel                     PC_SEQ / PC_BR / PC_JMP
//   ex/mem/wb_ctrl, *_dst      stage registers
//   fwd_a, fwd_b               forwarding selects (HAZARD_FORWARDING_EN only)
// Macro HAZARD_FORWARDING_EN adds the EX-stage forwarding selects.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CW_W-1:0]  id_ctrl,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             ex_alu_zero,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic [1:0]       pc_sel,
    output logic [CW_W-1:0]  ex_ctrl,
    output logic [CW_W-1:0]  mem_ctrl,
    output logic [CW_W-1:0]  wb_ctrl,
    output logic [REG_W-1:0] ex_dst,
    output logic [REG_W-1:0] mem_dst,
    output logic [REG_W-1:0] wb_dst
`ifdef HAZARD_FORWARDING_EN
    ,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
`endif
);

    state_t     state;
    logic [1:0] stall_cnt;

    logic       stall_req;
    logic [1:0] stall_len;
    logic       br_taken;
    logic       stall;
    logic       id_jump;
    logic       bubble;

    hazard_detect u_hazard_detect (
        .ex_reg_write  (ex_ctrl[CW_REGWRITE]),
        .ex_mem_read   (ex_ctrl[CW_MEMREAD]),
        .ex_dst        (ex_dst),
        .mem_reg_write (mem_ctrl[CW_REGWRITE]),
        .mem_dst       (mem_dst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .stall_req     (stall_req),
        .stall_len     (stall_len)
    );

    // Priority: taken branch > stall > jump.
    always_comb begin
        br_taken = (ex_ctrl[CW_BREQ] & ex_alu_zero) |
                   (ex_ctrl[CW_BRNE] & ~ex_alu_zero);
        stall    = ~br_taken & ((state == ST_STALL) | stall_req);
        id_jump  = ~br_taken & ~stall &
                   (id_ctrl[CW_JUMP] | id_ctrl[CW_JAL]);
        bubble   = stall | br_taken;

        pc_write   = ~stall;
        ifid_write = ~stall;
        ifid_flush = br_taken | id_jump;

        if (br_taken)
            pc_sel = PC_BR;
        else if (id_jump)
            pc_sel = PC_JMP;
        else
            pc_sel = PC_SEQ;
    end

    // stall_cnt holds the stall cycles still owed after the current one,
    // so the detecting RUN cycle is itself the first stall cycle and a
    // one-cycle stall returns to RUN (re-evaluating the held instruction)
    // without lingering in STALL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
            ex_ctrl   <= CTRL_NOP;
            mem_ctrl  <= CTRL_NOP;
            wb_ctrl   <= CTRL_NOP;
            ex_dst    <= '0;
            mem_dst   <= '0;
            wb_dst    <= '0;
        end else begin
            mem_ctrl <= ex_ctrl;
            wb_ctrl  <= mem_ctrl;
            mem_dst  <= ex_dst;
            wb_dst   <= mem_dst;

            if (bubble) begin
                ex_ctrl <= CTRL_NOP;
                ex_dst  <= '0;
            end else begin
                ex_ctrl <= id_ctrl;
                ex_dst  <= id_dst;
            end

            if (br_taken) begin
                state     <= ST_RUN;
                stall_cnt <= '0;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (stall_req && (stall_len > 2'd1)) begin
                            state     <= ST_STALL;
                            stall_cnt <= stall_len - 2'd1;
                        end else begin
                            stall_cnt <= '0;
                        end
                    end
                    ST_STALL: begin
                        stall_cnt <= stall_cnt - 2'd1;
                        if (stall_cnt <= 2'd1)
                            state <= ST_RUN;
                    end
                    default: begin
                        state     <= ST_RUN;
                        stall_cnt <= '0;
                    end
                endcase
            end
        end
    end

`ifdef HAZARD_FORWARDING_EN
    logic [REG_W-1:0] ex_rs;
    logic [REG_W-1:0] ex_rt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_rs <= '0;
            ex_rt <= '0;
        end else if (bubble) begin
            ex_rs <= '0;
            ex_rt <= '0;
        end else begin
            ex_rs <= id_rs;
            ex_rt <= id_rt;
        end
    end

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (mem_ctrl[CW_REGWRITE] && (mem_dst != '0) && (mem_dst == ex_rs))
            fwd_a = FWD_EXMEM;
        else if (wb_ctrl[CW_REGWRITE] && (wb_dst != '0) && (wb_dst == ex_rs))
            fwd_a = FWD_MEMWB;
        if (mem_ctrl[CW_REGWRITE] && (mem_dst != '0) && (mem_dst == ex_rt))
            fwd_b = FWD_EXMEM;
        else if (wb_ctrl[CW_REGWRITE] && (wb_dst != '0) && (wb_dst == ex_rt))
            fwd_b = FWD_MEMWB;
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed scenarios followed by randomized instruction streams, checked
// every cycle against a behavioural pipeline model kept in the bench.
// Optional feature macro: HAZARD_FORWARDING_EN (adds fwd_a/fwd_b checks).
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam logic [14:0] C_NOP  = 15'd0;
    localparam logic [14:0] C_ADD  = 15'((1 << 14) | (1 << 13) | 2);
    localparam logic [14:0] C_ADDI = 15'((1 << 13) | (1 << 5) | (1 << 4) | 2);
    localparam logic [14:0] C_LW   = 15'((1 << 13) | (1 << 12) | (1 << 9) | (1 << 5) | (1 << 4));
    localparam logic [14:0] C_SW   = 15'((1 << 8) | (1 << 5) | (1 << 4));
    localparam logic [14:0] C_BEQ  = 15'((1 << 7) | 6);
    localparam logic [14:0] C_BNE  = 15'((1 << 6) | 6);
    localparam logic [14:0] C_J    = 15'(1 << 11);
    localparam logic [14:0] C_JAL  = 15'((1 << 10) | (1 << 13));

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] id_ctrl;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        id_uses_rt;
    logic        ex_alu_zero;
    logic        pc_write, ifid_write, ifid_flush;
    logic [1:0]  pc_sel;
    logic [14:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [4:0]  ex_dst, mem_dst, wb_dst;
`ifdef HAZARD_FORWARDING_EN
    logic [1:0]  fwd_a, fwd_b;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_ctrl     (id_ctrl),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .id_dst      (id_dst),
        .ex_alu_zero (ex_alu_zero),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .ifid_flush  (ifid_flush),
        .pc_sel      (pc_sel),
        .ex_ctrl     (ex_ctrl),
        .mem_ctrl    (mem_ctrl),
        .wb_ctrl     (wb_ctrl),
        .ex_dst      (ex_dst),
        .mem_dst     (mem_dst),
        .wb_dst      (wb_dst)
`ifdef HAZARD_FORWARDING_EN
        ,
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: stage contents (0 = EX, 1 = MEM, 2 = WB) and stall cycles owed.
    logic [14:0] m_cw  [3];
    logic [4:0]  m_dst [3];
    logic [4:0]  m_rs, m_rt;
    int          m_owed;

    // Observations from the most recent step.
    logic [4:0]  o_ctl;
    logic [14:0] o_ex;
    logic [44:0] o_words;
    bit          last_stalled;
    bit          last_flush;

    function automatic bit writes_src(input logic [14:0] c, input logic [4:0] d,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input bit urt);
        return c[13] && (d != 0) && ((d == rs) || (urt && d == rt));
    endfunction

    function automatic logic [1:0] fwd_model(input logic [4:0] src);
        if (m_cw[1][13] && m_dst[1] != 0 && m_dst[1] == src) return 2'd1;
        if (m_cw[2][13] && m_dst[2] != 0 && m_dst[2] == src) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_cw[i]  = '0;
            m_dst[i] = '0;
        end
        m_rs   = '0;
        m_rt   = '0;
        m_owed = 0;
    endtask

    // One clock cycle: drive ID inputs, check DUT against the model, advance model.
    task automatic step(input logic [14:0] cw, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] dst, input bit urt, input bit zero, input bit rstn);
        bit br, hx, hm, lu, stalled, jmp;
        int len;
        logic [1:0] sel;
        @(negedge clk);
        id_ctrl     = cw;
        id_rs       = rs;
        id_rt       = rt;
        id_dst      = dst;
        id_uses_rt  = urt;
        ex_alu_zero = zero;
        rst_n       = rstn;
        #1;
        br = (m_cw[0][7] && zero) || (m_cw[0][6] && !zero);
        hx = writes_src(m_cw[0], m_dst[0], rs, rt, urt);
        hm = writes_src(m_cw[1], m_dst[1], rs, rt, urt);
        lu = hx && m_cw[0][9];
`ifdef HAZARD_FORWARDING_EN
        len = lu ? 1 : 0;
`else
        len = lu ? 1 : hx ? 2 : hm ? 1 : 0;
`endif
        stalled = !br && (m_owed > 0 || len > 0);
        jmp = !br && !stalled && (cw[11] || cw[10]);
        sel = br ? 2'd1 : jmp ? 2'd2 : 2'd0;

        check("ctl", {pc_write, ifid_write, ifid_flush, pc_sel},
              {!stalled, !stalled, br || jmp, sel});
        check("ctrl_words", {ex_ctrl, mem_ctrl, wb_ctrl}, {m_cw[0], m_cw[1], m_cw[2]});
        check("dsts", {ex_dst, mem_dst, wb_dst}, {m_dst[0], m_dst[1], m_dst[2]});
`ifdef HAZARD_FORWARDING_EN
        check("fwd", {fwd_a, fwd_b}, {fwd_model(m_rs), fwd_model(m_rt)});
`endif
        o_ctl        = {pc_write, ifid_write, ifid_flush, pc_sel};
        o_ex         = ex_ctrl;
        o_words      = {ex_ctrl, mem_ctrl, wb_ctrl};
        last_stalled = stalled;
        last_flush   = br || jmp;

        if (!rstn) begin
            model_clear();
        end else begin
            if (br)            m_owed = 0;
            else if (m_owed > 0) m_owed--;
            else if (len > 0)  m_owed = len - 1;
            m_cw[2]  = m_cw[1];
            m_dst[2] = m_dst[1];
            m_cw[1]  = m_cw[0];
            m_dst[1] = m_dst[0];
            m_cw[0]  = (stalled || br) ? 15'd0 : cw;
            m_dst[0] = (stalled || br) ? 5'd0 : dst;
            m_rs     = (stalled || br) ? 5'd0 : rs;
            m_rt     = (stalled || br) ? 5'd0 : rt;
        end
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(C_NOP, 0, 0, 0, 0, 0, 1);
    endtask

    logic [14:0] h_cw;
    logic [4:0]  h_rs, h_rt, h_dst;
    bit          h_urt;

    initial begin
        rst_n = 1'b0;
        id_ctrl = '0; id_rs = '0; id_rt = '0; id_dst = '0;
        id_uses_rt = 1'b0; ex_alu_zero = 1'b0;
        model_clear();
        // Undefined registers before the first reset edge: skip checking it.
        @(negedge clk); @(negedge clk);
        step(C_NOP, 0, 0, 0, 0, 0, 0);
        step(C_NOP, 0, 0, 0, 0, 0, 1);
        check("reset_ctl", 64'(o_ctl), 64'(5'b11000));
        check("reset_words", 64'(o_words), 64'd0);

        // Load-use: lw $2 ; add $3,$2,$4
        step(C_LW, 1, 0, 2, 0, 0, 1);
        step(C_ADD, 2, 4, 3, 1, 0, 1);
        check("lu_stall", 64'(o_ctl), 64'(5'b00000));
        step(C_ADD, 2, 4, 3, 1, 0, 1);
        check("lu_bubble", 64'(o_ex), 64'd0);
        for (int i = 0; i < 4 && last_stalled; i++) step(C_ADD, 2, 4, 3, 1, 0, 1);
        step(C_NOP, 0, 0, 0, 0, 0, 1);
        check("lu_issue", 64'(o_ex), 64'(C_ADD));
        nops(3);

        // Taken beq squashes the ID instruction; bne with zero is not taken.
        step(C_BEQ, 1, 1, 0, 1, 0, 1);
        step(C_ADD, 0, 0, 3, 1, 1, 1);
        check("beq_taken", 64'(o_ctl), 64'(5'b11101));
        step(C_NOP, 0, 0, 0, 0, 0, 1);
        check("beq_squash", 64'(o_ex), 64'd0);
        step(C_BNE, 1, 1, 0, 1, 0, 1);
        step(C_NOP, 0, 0, 0, 0, 1, 1);
        check("bne_not_taken", 64'(o_ctl), 64'(5'b11000));
        nops(3);

        // Jump: one-cycle flush, jump itself proceeds.
        step(C_J, 0, 0, 0, 0, 0, 1);
        check("jump", 64'(o_ctl), 64'(5'b11110));
        step(C_NOP, 0, 0, 0, 0, 0, 1);
        check("jump_ex", 64'(o_ex), 64'(C_J));
        check("jump_once", 64'(o_ctl), 64'(5'b11000));
        nops(3);

        // addi $5 ; add $6,$5,$5
        step(C_ADDI, 1, 0, 5, 0, 0, 1);
        step(C_ADD, 5, 5, 6, 1, 0, 1);
`ifdef HAZARD_FORWARDING_EN
        check("raw_no_stall", 64'(o_ctl), 64'(5'b11000));
        step(C_NOP, 0, 0, 0, 0, 0, 1);
        check("raw_fwd", 64'({fwd_a, fwd_b}), 64'(4'b0101));
`else
        check("raw_stall1", 64'(o_ctl), 64'(5'b00000));
        step(C_ADD, 5, 5, 6, 1, 0, 1);
        check("raw_stall2", 64'(o_ctl), 64'(5'b00000));
        step(C_ADD, 5, 5, 6, 1, 0, 1);
        check("raw_release", 64'(o_ctl), 64'(5'b11000));
`endif
        nops(3);

        // $0 writer then $0 reader: no hazard.
        step(C_ADDI, 1, 0, 0, 0, 0, 1);
        step(C_ADD, 0, 0, 7, 1, 0, 1);
        check("zero_reg", 64'(o_ctl), 64'(5'b11000));
        nops(3);

        // Reset in the middle of a stall with a populated pipeline.
        step(C_ADDI, 1, 0, 5, 0, 0, 1);
        step(C_ADD, 5, 5, 6, 1, 0, 1);
        step(C_ADD, 5, 5, 6, 1, 0, 0);
        step(C_NOP, 0, 0, 0, 0, 0, 1);
        check("rst_mid_ctl", 64'(o_ctl), 64'(5'b11000));
        check("rst_mid_words", 64'(o_words), 64'd0);

        // Random instruction stream; stalls hold ID, flushes present a NOP.
        h_cw = C_NOP; h_rs = 0; h_rt = 0; h_dst = 0; h_urt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!last_stalled) begin
                if (last_flush) begin
                    h_cw = C_NOP; h_rs = 0; h_rt = 0; h_dst = 0; h_urt = 0;
                end else begin
                    case ($urandom_range(0, 9))
                        0:       begin h_cw = C_NOP;  h_urt = 0; end
                        1, 2:    begin h_cw = C_ADD;  h_urt = 1; end
                        3:       begin h_cw = C_ADDI; h_urt = 0; end
                        4:       begin h_cw = C_LW;   h_urt = 0; end
                        5:       begin h_cw = C_SW;   h_urt = 1; end
                        6:       begin h_cw = C_BEQ;  h_urt = 1; end
                        7:       begin h_cw = C_BNE;  h_urt = 1; end
                        8:       begin h_cw = C_J;    h_urt = 0; end
                        default: begin h_cw = C_JAL;  h_urt = 0; end
                    endcase
                    h_rs  = 5'($urandom_range(0, 3));
                    h_rt  = 5'($urandom_range(0, 3));
                    h_dst = h_cw[13] ? 5'($urandom_range(0, 3)) : 5'd0;
                end
            end
            step(h_cw, h_rs, h_rt, h_dst, h_urt, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 79) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
